// File: rtl/tlu_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlu_emulator_pkg
// Brief    : Mode and FSM encodings shared by the TLU emulator and the
//            DUT-side TLU controller.
// Revision : 1.0 - initial release
// ============================================================================
package tlu_emulator_pkg;

    typedef logic [1:0] tlu_mode_t;

    localparam tlu_mode_t TLU_MODE_DISABLED  = 2'b00;
    localparam tlu_mode_t TLU_MODE_NO_HS     = 2'b01;
    localparam tlu_mode_t TLU_MODE_SIMPLE_HS = 2'b10;
    localparam tlu_mode_t TLU_MODE_DATA_HS   = 2'b11;

    localparam logic [2:0] TLU_ST_IDLE         = 3'd0;
    localparam logic [2:0] TLU_ST_TRIG         = 3'd1;
    localparam logic [2:0] TLU_ST_DATA         = 3'd2;
    localparam logic [2:0] TLU_ST_WAIT_RELEASE = 3'd3;
    localparam logic [2:0] TLU_ST_RST_PULSE    = 3'd4;
    localparam logic [2:0] TLU_ST_HOLDOFF      = 3'd5;

    function automatic logic tlu_mode_handshake(input tlu_mode_t mode);
        return (mode == TLU_MODE_SIMPLE_HS) || (mode == TLU_MODE_DATA_HS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlu_emulator_input_sync.sv
`default_nettype none
// ============================================================================
// Module   : tlu_emulator_input_sync
// Brief    : 3-FF synchronizer with a registered rising-edge flag aligned to
//            the synchronized level (3-cycle latency for both).
// Revision : 1.0 - initial release
// ============================================================================
module tlu_emulator_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [2:0] sync_ff;
    logic       rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 3'b000;
            rise_q  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[1:0], async_in};
            rise_q  <= sync_ff[1] & ~sync_ff[2];
        end
    end

    assign level = sync_ff[2];
    assign rise  = rise_q;

endmodule
`default_nettype wire

// File: rtl/tlu_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tlu_emulator
// Brief    : EUDET TLU trigger-source emulator (trigger, handshake, serial
//            trigger number). Optional TLU_RESET pulse via TLU_EMULATOR_RESET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tlu_emulator #(
    parameter int TRIGGER_NUMBER_BITS = 16,
    parameter int HOLDOFF_CYCLES      = 4
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST_N,
    input  logic                           ENABLE,
    input  logic [1:0]                     MODE,
    input  logic                           TRIGGER_REQ,
    input  logic [7:0]                     TRIGGER_PULSE_LEN,
    input  logic [15:0]                    TIMEOUT,
    input  logic                           MSB_FIRST,
    input  logic                           LOAD_NUMBER,
    input  logic [TRIGGER_NUMBER_BITS-1:0] LOAD_VALUE,
    input  logic                           RESET_REQ,
    input  logic                           CLEAR_ERROR,
    input  logic                           TLU_CLOCK,
    input  logic                           TLU_BUSY,
    output logic                           TLU_TRIGGER,
    output logic                           TLU_RESET,
    output logic [TRIGGER_NUMBER_BITS-1:0] TRIGGER_NUMBER,
    output logic                           BUSY,
    output logic                           TIMEOUT_ERROR,
    output logic                           REQ_DROPPED
);

    import tlu_emulator_pkg::*;

    localparam int         NB        = TRIGGER_NUMBER_BITS;
    localparam logic [15:0] HOLD_LAST = (HOLDOFF_CYCLES > 1) ? 16'(HOLDOFF_CYCLES - 1) : 16'd0;

    logic busy_lvl, busy_rise, clk_lvl, clk_rise;

    tlu_emulator_input_sync u_sync_busy (
        .clk      (BUS_CLK),
        .rst_n    (BUS_RST_N),
        .async_in (TLU_BUSY),
        .level    (busy_lvl),
        .rise     (busy_rise)
    );

    tlu_emulator_input_sync u_sync_clock (
        .clk      (BUS_CLK),
        .rst_n    (BUS_RST_N),
        .async_in (TLU_CLOCK),
        .level    (clk_lvl),
        .rise     (clk_rise)
    );

    logic [2:0]    state, state_nx;
    tlu_mode_t     mode_q, mode_nx;
    logic          msb_q, msb_nx;
    logic [15:0]   cnt, cnt_nx;
    logic [NB-1:0] sr, sr_nx, number, number_rev;
    logic          trig_q, trig_nx, rst_q, rst_nx, drop_q, err_q;
    logic          inc, clear_num, err_set, reset_take, accept_trig;
    logic [7:0]    len_last;
    logic          pulse_done, timeout_hit, hold_done;

    always_comb begin
        number_rev = '0;
        for (int i = 0; i < NB; i++) begin
            number_rev[i] = number[NB-1-i];
        end
    end

    // A pulse length of 0 behaves as 1; cnt counts cycles spent in the state.
    assign len_last    = (TRIGGER_PULSE_LEN == 8'd0) ? 8'd0 : TRIGGER_PULSE_LEN - 8'd1;
    assign pulse_done  = (cnt == {8'd0, len_last});
    assign timeout_hit = (TIMEOUT != 16'd0) && (cnt == TIMEOUT - 16'd1);
    assign hold_done   = (cnt >= HOLD_LAST);

`ifdef TLU_EMULATOR_RESET_EN
    assign reset_take = RESET_REQ && ENABLE && (state == TLU_ST_IDLE);
`else
    assign reset_take = 1'b0;
`endif

    assign accept_trig = TRIGGER_REQ && ENABLE && (state == TLU_ST_IDLE)
                         && (MODE != TLU_MODE_DISABLED) && !reset_take;

    always_comb begin
        state_nx  = state;
        mode_nx   = mode_q;
        msb_nx    = msb_q;
        cnt_nx    = cnt + 16'd1;
        sr_nx     = sr;
        trig_nx   = trig_q;
        rst_nx    = rst_q;
        inc       = 1'b0;
        clear_num = 1'b0;
        err_set   = 1'b0;
        case (state)
            TLU_ST_IDLE: begin
                cnt_nx  = 16'd0;
                trig_nx = 1'b0;
                rst_nx  = 1'b0;
                if (reset_take) begin
                    state_nx  = TLU_ST_RST_PULSE;
                    rst_nx    = 1'b1;
                    clear_num = 1'b1;
                end else if (accept_trig) begin
                    state_nx = TLU_ST_TRIG;
                    trig_nx  = 1'b1;
                    mode_nx  = MODE;
                    msb_nx   = MSB_FIRST;
                end
            end
            TLU_ST_TRIG: begin
                if (!tlu_mode_handshake(mode_q)) begin
                    if (pulse_done) begin
                        trig_nx  = 1'b0;
                        inc      = 1'b1;
                        cnt_nx   = 16'd0;
                        state_nx = TLU_ST_HOLDOFF;
                    end
                end else if (busy_lvl) begin
                    trig_nx = 1'b0;
                    cnt_nx  = 16'd0;
                    if (mode_q == TLU_MODE_DATA_HS) begin
                        state_nx = TLU_ST_DATA;
                        sr_nx    = msb_q ? number_rev : number;
                    end else begin
                        state_nx = TLU_ST_WAIT_RELEASE;
                    end
                end else if (timeout_hit) begin
                    err_set  = 1'b1;
                    trig_nx  = 1'b0;
                    cnt_nx   = 16'd0;
                    state_nx = TLU_ST_HOLDOFF;
                end else if (clk_rise) begin
                    cnt_nx = 16'd0;
                end
            end
            TLU_ST_DATA: begin
                if (!busy_lvl || (!clk_rise && timeout_hit)) begin
                    err_set  = busy_lvl;
                    inc      = 1'b1;
                    trig_nx  = 1'b0;
                    cnt_nx   = 16'd0;
                    state_nx = TLU_ST_HOLDOFF;
                end else if (clk_rise) begin
                    // Zero fill keeps the line low once the word is exhausted.
                    trig_nx = sr[0];
                    sr_nx   = {1'b0, sr[NB-1:1]};
                    cnt_nx  = 16'd0;
                end
            end
            TLU_ST_WAIT_RELEASE: begin
                if (!busy_lvl || (!clk_rise && timeout_hit)) begin
                    err_set  = busy_lvl;
                    inc      = 1'b1;
                    trig_nx  = 1'b0;
                    cnt_nx   = 16'd0;
                    state_nx = TLU_ST_HOLDOFF;
                end else if (clk_rise) begin
                    cnt_nx = 16'd0;
                end
            end
`ifdef TLU_EMULATOR_RESET_EN
            TLU_ST_RST_PULSE: begin
                if (pulse_done) begin
                    rst_nx   = 1'b0;
                    cnt_nx   = 16'd0;
                    state_nx = TLU_ST_HOLDOFF;
                end
            end
`endif
            TLU_ST_HOLDOFF: begin
                trig_nx = 1'b0;
                rst_nx  = 1'b0;
                if (hold_done) begin
                    cnt_nx   = 16'd0;
                    state_nx = TLU_ST_IDLE;
                end
            end
            default: begin
                trig_nx  = 1'b0;
                rst_nx   = 1'b0;
                cnt_nx   = 16'd0;
                state_nx = TLU_ST_IDLE;
            end
        endcase
        // Disabling aborts silently: no count, no error.
        if (!ENABLE) begin
            state_nx  = TLU_ST_IDLE;
            trig_nx   = 1'b0;
            rst_nx    = 1'b0;
            cnt_nx    = 16'd0;
            inc       = 1'b0;
            err_set   = 1'b0;
            clear_num = 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state  <= TLU_ST_IDLE;
            mode_q <= TLU_MODE_DISABLED;
            msb_q  <= 1'b0;
            cnt    <= 16'd0;
            sr     <= '0;
            trig_q <= 1'b0;
            rst_q  <= 1'b0;
            drop_q <= 1'b0;
            err_q  <= 1'b0;
            number <= '0;
        end else begin
            state  <= state_nx;
            mode_q <= mode_nx;
            msb_q  <= msb_nx;
            cnt    <= cnt_nx;
            sr     <= sr_nx;
            trig_q <= trig_nx;
            rst_q  <= rst_nx;
            drop_q <= TRIGGER_REQ && !accept_trig;
            err_q  <= err_set | (err_q & ~CLEAR_ERROR);
            if (LOAD_NUMBER) begin
                number <= LOAD_VALUE;
            end else if (clear_num) begin
                number <= '0;
            end else if (inc) begin
                number <= number + 1'b1;
            end
        end
    end

    assign TLU_TRIGGER    = trig_q & ENABLE;
    assign TRIGGER_NUMBER = number;
    assign BUSY           = (state != TLU_ST_IDLE);
    assign TIMEOUT_ERROR  = err_q;
    assign REQ_DROPPED    = drop_q;

    logic unused_ok;
`ifdef TLU_EMULATOR_RESET_EN
    assign TLU_RESET = rst_q & ENABLE;
    assign unused_ok = busy_rise ^ clk_lvl;
`else
    assign TLU_RESET = 1'b0;
    assign unused_ok = busy_rise ^ clk_lvl ^ RESET_REQ ^ rst_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlu_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlu_emulator
// Brief    : Directed self-checking bench for tlu_emulator with a scoreboard
//            of expected trigger numbers and serial bits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlu_emulator;

    localparam int NB   = 16;
    localparam int HOLD = 4;

    logic          BUS_CLK = 1'b0;
    logic          BUS_RST_N;
    logic          ENABLE;
    logic [1:0]    MODE;
    logic          TRIGGER_REQ;
    logic [7:0]    TRIGGER_PULSE_LEN;
    logic [15:0]   TIMEOUT;
    logic          MSB_FIRST;
    logic          LOAD_NUMBER;
    logic [NB-1:0] LOAD_VALUE;
    logic          RESET_REQ;
    logic          CLEAR_ERROR;
    logic          TLU_CLOCK;
    logic          TLU_BUSY;
    logic          TLU_TRIGGER;
    logic          TLU_RESET;
    logic [NB-1:0] TRIGGER_NUMBER;
    logic          BUSY;
    logic          TIMEOUT_ERROR;
    logic          REQ_DROPPED;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_num[$];
    logic        exp_bits[$];

    tlu_emulator #(
        .TRIGGER_NUMBER_BITS (NB),
        .HOLDOFF_CYCLES      (HOLD)
    ) dut (
        .BUS_CLK           (BUS_CLK),
        .BUS_RST_N         (BUS_RST_N),
        .ENABLE            (ENABLE),
        .MODE              (MODE),
        .TRIGGER_REQ       (TRIGGER_REQ),
        .TRIGGER_PULSE_LEN (TRIGGER_PULSE_LEN),
        .TIMEOUT           (TIMEOUT),
        .MSB_FIRST         (MSB_FIRST),
        .LOAD_NUMBER       (LOAD_NUMBER),
        .LOAD_VALUE        (LOAD_VALUE),
        .RESET_REQ         (RESET_REQ),
        .CLEAR_ERROR       (CLEAR_ERROR),
        .TLU_CLOCK         (TLU_CLOCK),
        .TLU_BUSY          (TLU_BUSY),
        .TLU_TRIGGER       (TLU_TRIGGER),
        .TLU_RESET         (TLU_RESET),
        .TRIGGER_NUMBER    (TRIGGER_NUMBER),
        .BUSY              (BUSY),
        .TIMEOUT_ERROR     (TIMEOUT_ERROR),
        .REQ_DROPPED       (REQ_DROPPED)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic pulse_req();
        TRIGGER_REQ = 1'b1;
        tick();
        TRIGGER_REQ = 1'b0;
    endtask

    task automatic load_number(input logic [15:0] val);
        LOAD_VALUE  = val;
        LOAD_NUMBER = 1'b1;
        tick();
        LOAD_NUMBER = 1'b0;
        check("load_value", 32'(TRIGGER_NUMBER), 32'(val));
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (BUSY && n < max) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(BUSY), 32'd0);
    endtask

    task automatic pop_number(input string tag);
        logic [15:0] e;
        if (exp_num.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_num.pop_front();
            check(tag, 32'(TRIGGER_NUMBER), 32'(e));
        end
    endtask

    // Emulates the DUT side of a trigger-data handshake (12-cycle TLU_CLOCK).
    task automatic run_data_txn(input logic msb, input logic [15:0] val, input logic with_drop);
        logic [15:0] v;
        logic        b;
        int          n;
        v = val;
        load_number(v);
        for (int i = 0; i < NB; i++) begin
            exp_bits.push_back(msb ? v[NB-1-i] : v[i]);
        end
        exp_num.push_back(v + 16'd1);
        MODE      = 2'b11;
        MSB_FIRST = msb;
        pulse_req();
        check("data_trig_rise", 32'(TLU_TRIGGER), 32'd1);
        MODE      = 2'b01;
        MSB_FIRST = ~msb;
        TLU_BUSY  = 1'b1;
        n = 0;
        while (TLU_TRIGGER && n < 10) begin
            tick();
            n++;
        end
        check("data_trig_fall", 32'(TLU_TRIGGER), 32'd0);
        if (with_drop) begin
            TRIGGER_REQ = 1'b1;
            tick();
            TRIGGER_REQ = 1'b0;
            check("drop_pulse", 32'(REQ_DROPPED), 32'd1);
            tick();
            check("drop_pulse_end", 32'(REQ_DROPPED), 32'd0);
            check("drop_no_retrigger", 32'(TLU_TRIGGER), 32'd0);
        end
        for (int i = 0; i < NB; i++) begin
            TLU_CLOCK = 1'b1;
            repeat (6) tick();
            b = exp_bits.pop_front();
            check($sformatf("data_bit%0d_msb%0d", i, msb), 32'(TLU_TRIGGER), 32'(b));
            TLU_CLOCK = 1'b0;
            repeat (6) tick();
        end
        TLU_BUSY = 1'b0;
        wait_idle(30);
        pop_number("data_number");
    endtask

    initial begin
        logic [11:0] trig_seen, busy_seen, trig_exp, busy_exp;
        logic        hi;
        int          n;
        logic [15:0] model_num;

        BUS_RST_N         = 1'b0;
        ENABLE            = 1'b0;
        MODE              = 2'b00;
        TRIGGER_REQ       = 1'b0;
        TRIGGER_PULSE_LEN = 8'd5;
        TIMEOUT           = 16'd0;
        MSB_FIRST         = 1'b0;
        LOAD_NUMBER       = 1'b0;
        LOAD_VALUE        = '0;
        RESET_REQ         = 1'b0;
        CLEAR_ERROR       = 1'b0;
        TLU_CLOCK         = 1'b0;
        TLU_BUSY          = 1'b0;

        #23;
        check("reset_outputs",
              {11'd0, TLU_TRIGGER, TLU_RESET, BUSY, TIMEOUT_ERROR, REQ_DROPPED, TRIGGER_NUMBER}, 32'd0);
        tick();
        BUS_RST_N = 1'b1;
        ENABLE    = 1'b1;
        repeat (3) tick();
        check("post_reset_number", 32'(TRIGGER_NUMBER), 32'd0);

        // Mode 01: fixed-length pulse, count, holdoff.
        MODE = 2'b01;
        exp_num.push_back(16'd1);
        pulse_req();
        for (int i = 0; i < 12; i++) begin
            trig_seen[i] = TLU_TRIGGER;
            busy_seen[i] = BUSY;
            trig_exp[i]  = (i < 5);
            busy_exp[i]  = (i < 5 + HOLD);
            if (i < 11) tick();
        end
        check("m01_trigger_pulse", 32'(trig_seen), 32'(trig_exp));
        check("m01_busy_window", 32'(busy_seen), 32'(busy_exp));
        pop_number("m01_number");

        // Mode 10: simple handshake.
        MODE = 2'b10;
        exp_num.push_back(16'd2);
        pulse_req();
        hi = 1'b1;
        repeat (20) begin
            hi &= TLU_TRIGGER;
            tick();
        end
        check("m10_trigger_held", 32'(hi), 32'd1);
        TLU_BUSY = 1'b1;
        n = 0;
        while (TLU_TRIGGER && n < 10) begin
            tick();
            n++;
        end
        check("m10_fall_latency", 32'((n >= 1) && (n <= 4)), 32'd1);
        repeat (50) tick();
        check("m10_no_early_inc", 32'(TRIGGER_NUMBER), 32'd1);
        TLU_BUSY = 1'b0;
        n = 0;
        while (TRIGGER_NUMBER == 16'd1 && n < 10) begin
            tick();
            n++;
        end
        check("m10_inc_latency", 32'((n >= 1) && (n <= 4)), 32'd1);
        wait_idle(20);
        pop_number("m10_number");

        // Mode 11: serial trigger number, LSB then MSB first (with a dropped request).
        run_data_txn(1'b0, 16'hA5C3, 1'b0);
        run_data_txn(1'b1, 16'hA5C3, 1'b1);

        // Mode 10 timeout: DUT never answers.
        MODE    = 2'b10;
        TIMEOUT = 16'd100;
        pulse_req();
        n = 0;
        while (TLU_TRIGGER && n < 200) begin
            n++;
            tick();
        end
        check("timeout_length", 32'((n >= 98) && (n <= 102)), 32'd1);
        check("timeout_error_set", 32'(TIMEOUT_ERROR), 32'd1);
        check("timeout_no_inc", 32'(TRIGGER_NUMBER), 32'hA5C4);
        wait_idle(20);
        check("timeout_error_sticky", 32'(TIMEOUT_ERROR), 32'd1);
        CLEAR_ERROR = 1'b1;
        tick();
        CLEAR_ERROR = 1'b0;
        check("timeout_error_cleared", 32'(TIMEOUT_ERROR), 32'd0);
        TIMEOUT = 16'd0;

        // Counter wrap.
        load_number(16'hFFFF);
        MODE = 2'b01;
        exp_num.push_back(16'h0000);
        pulse_req();
        wait_idle(30);
        pop_number("wrap_number");

        // TLU_RESET request.
        load_number(16'd7);
        model_num = 16'd7;
`ifdef TLU_EMULATOR_RESET_EN
        RESET_REQ   = 1'b1;
        TRIGGER_REQ = 1'b1;
        tick();
        RESET_REQ   = 1'b0;
        TRIGGER_REQ = 1'b0;
        check("rst_req_dropped", 32'(REQ_DROPPED), 32'd1);
        check("rst_counter_clear", 32'(TRIGGER_NUMBER), 32'd0);
        check("rst_no_trigger", 32'(TLU_TRIGGER), 32'd0);
        n = 0;
        while (TLU_RESET && n < 20) begin
            n++;
            tick();
        end
        check("rst_pulse_len", 32'(n), 32'd5);
        wait_idle(20);
        model_num = 16'd0;
`else
        RESET_REQ = 1'b1;
        tick();
        RESET_REQ = 1'b0;
        check("rst_ignored_line", 32'(TLU_RESET), 32'd0);
        check("rst_ignored_busy", 32'(BUSY), 32'd0);
        tick();
        check("rst_ignored_number", 32'(TRIGGER_NUMBER), 32'd7);
`endif

        // ENABLE low mid-transaction aborts quietly.
        MODE = 2'b10;
        pulse_req();
        repeat (3) tick();
        check("en_trigger_active", 32'(TLU_TRIGGER), 32'd1);
        ENABLE = 1'b0;
        #1;
        check("en_trigger_forced_low", 32'(TLU_TRIGGER), 32'd0);
        tick();
        check("en_busy_idle", 32'(BUSY), 32'd0);
        check("en_number_kept", 32'(TRIGGER_NUMBER), 32'(model_num));
        check("en_no_error", 32'(TIMEOUT_ERROR), 32'd0);
        pulse_req();
        check("en_req_dropped", 32'(REQ_DROPPED), 32'd1);
        check("en_no_start", 32'(BUSY), 32'd0);
        ENABLE = 1'b1;
        tick();

        // Asynchronous reset in the middle of a data transfer.
        load_number(16'h0003);
        MODE      = 2'b11;
        MSB_FIRST = 1'b0;
        pulse_req();
        TLU_BUSY = 1'b1;
        n = 0;
        while (TLU_TRIGGER && n < 10) begin
            tick();
            n++;
        end
        TLU_CLOCK = 1'b1;
        repeat (6) tick();
        check("async_mid_data_bit0", 32'(TLU_TRIGGER), 32'd1);
        #2;
        BUS_RST_N = 1'b0;
        #1;
        check("async_reset_outputs",
              {11'd0, TLU_TRIGGER, TLU_RESET, BUSY, TIMEOUT_ERROR, REQ_DROPPED, TRIGGER_NUMBER}, 32'd0);
        TLU_BUSY  = 1'b0;
        TLU_CLOCK = 1'b0;
        repeat (2) tick();
        BUS_RST_N = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlu_emulator.md
Name: tlu_emulator

Overview:
- Trigger-source end of the EUDET TLU 0.1/0.2 trigger interface.
- Emulates the TLU toward a DUT-side TLU controller: drives TLU_TRIGGER/TLU_RESET, reacts to the DUT's TLU_BUSY and TLU_CLOCK, and serially returns the trigger number.
- Used for lab self-test without a real TLU and as a bench stimulus for the trigger path; one emulator drives one DUT.

Parameters:
- TRIGGER_NUMBER_BITS, 16, width of trigger-number counter and serial data word.
- HOLDOFF_CYCLES, 4, idle BUS_CLK cycles forced after each transaction.

Ports:
- BUS_CLK  in  1  system clock.
- BUS_RST_N  in  1  reset, asynchronous, active-low.
- ENABLE  in  1  low forces IDLE immediately and drives all TLU outputs low.
- MODE  in  2  00 disabled, 01 no handshake, 10 simple handshake, 11 trigger-data handshake.
- TRIGGER_REQ  in  1  single-cycle request to issue one trigger.
- TRIGGER_PULSE_LEN  in  8  TLU_TRIGGER/TLU_RESET pulse length in BUS_CLK cycles; 0 is treated as 1.
- TIMEOUT  in  16  handshake timeout in cycles; 0 disables it.
- MSB_FIRST  in  1  serial bit order for mode 11.
- LOAD_NUMBER  in  1  load LOAD_VALUE into the counter.
- LOAD_VALUE  in  TRIGGER_NUMBER_BITS.
- RESET_REQ  in  1  request a TLU_RESET pulse (optional feature).
- CLEAR_ERROR  in  1  clears TIMEOUT_ERROR.
- TLU_CLOCK  in  1  asynchronous, from DUT.
- TLU_BUSY  in  1  asynchronous, from DUT.
- TLU_TRIGGER  out  1.
- TLU_RESET  out  1.
- TRIGGER_NUMBER  out  TRIGGER_NUMBER_BITS  number of the next trigger.
- BUSY  out  1  FSM not in IDLE.
- TIMEOUT_ERROR  out  1  sticky.
- REQ_DROPPED  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0, counter 0, FSM IDLE.
- Input capture: TLU_BUSY and TLU_CLOCK pass through a 3-FF synchronizer plus rising-edge flag; latency is 3 cycles.
- DUT constraint: TLU_CLOCK high and low phases each ≥4 BUS_CLK cycles.
- MODE and MSB_FIRST are latched when leaving IDLE; later changes have no effect until the next IDLE.
- FSM states: IDLE, TRIG, DATA, WAIT_RELEASE, RST_PULSE, HOLDOFF.
- IDLE:
  - TRIGGER_REQ with ENABLE=1 and MODE≠00 enters TRIG.
  - TLU_TRIGGER rises on the cycle after TRIGGER_REQ.
  - TRIGGER_REQ while not IDLE, or with ENABLE=0 or MODE=00, asserts REQ_DROPPED for 1 cycle.
- TRIG, mode 01:
  - Hold TLU_TRIGGER for TRIGGER_PULSE_LEN cycles.
  - Then increment the counter and enter HOLDOFF; TLU_BUSY is ignored.
- TRIG, modes 10/11:
  - Hold TLU_TRIGGER until synchronized BUSY is high, then drop it the next cycle.
  - Mode 10 goes to WAIT_RELEASE. Mode 11 loads the shift register with TRIGGER_NUMBER (bit-reversed if MSB_FIRST) and goes to DATA.
- DATA:
  - TLU_TRIGGER is 0 on entry.
  - Each synchronized TLU_CLOCK rising edge: TLU_TRIGGER <= sr[0], shift right, fill 0. The first edge presents bit 0 of the loaded word.
  - After TRIGGER_NUMBER_BITS edges TLU_TRIGGER stays 0; extra edges are tolerated.
  - Synchronized BUSY low ends the transaction.
- WAIT_RELEASE and DATA exit: on BUSY low, increment the counter (wraps 2^N−1→0), drive TLU_TRIGGER 0, enter HOLDOFF.
- HOLDOFF: HOLDOFF_CYCLES cycles, then IDLE.
- Timeout counter:
  - Cleared on state entry and on every TLU_CLOCK edge.
  - Expiry in TRIG: set TIMEOUT_ERROR, do not increment, go to HOLDOFF.
  - Expiry in DATA/WAIT_RELEASE: set TIMEOUT_ERROR, increment, go to HOLDOFF.
- Error flag: CLEAR_ERROR on the same cycle as a new error leaves the error set.
- Counter priority: LOAD_NUMBER > RESET_REQ clear > increment.
- ENABLE low mid-transaction: go to IDLE next cycle, outputs 0, counter unchanged, no error.

Optional Feature:
- Macro: TLU_EMULATOR_RESET_EN.
- Defined:
  - RESET_REQ in IDLE enters RST_PULSE: TLU_RESET high for TRIGGER_PULSE_LEN cycles, counter cleared to 0 on entry, then HOLDOFF.
  - RESET_REQ outside IDLE is ignored.
  - RESET_REQ together with TRIGGER_REQ in IDLE: reset wins and REQ_DROPPED pulses.
- Undefined: TLU_RESET is tied 0, RESET_REQ is ignored, and RST_PULSE does not exist.

Decomposition:
- Shared package/header: MODE encodings (TLU_MODE_DISABLED/NO_HS/SIMPLE_HS/DATA_HS) and FSM state encodings; the same constants are shared with the DUT-side controller.
- One sub-module: tlu_emulator_input_sync (3-FF synchronizer + rising-edge flag), instantiated for TLU_BUSY and TLU_CLOCK.

Test Plan:
- Mode 01, TRIGGER_PULSE_LEN=5, TRIGGER_REQ at cycle 10 -> TLU_TRIGGER high cycles 11–15, TRIGGER_NUMBER 0→1, BUSY low after HOLDOFF (cycle 20).
- Mode 10, DUT raises BUSY 20 cycles after trigger and drops it 50 cycles later -> TLU_TRIGGER falls ≤4 cycles after BUSY rise, counter increments ≤4 cycles after BUSY fall.
- Mode 11, LOAD_VALUE=16'hA5C3, 16 TLU_CLOCK cycles of 12 BUS_CLK -> sampled bits equal 16'hA5C3 LSB first; with MSB_FIRST=1, MSB first. Counter then reads 16'hA5C4.
- Mode 10, TIMEOUT=100, DUT never asserts BUSY -> TLU_TRIGGER drops at cycle ≈101, TIMEOUT_ERROR=1, counter unchanged; CLEAR_ERROR clears it.
- LOAD_VALUE=16'hFFFF then one mode-01 trigger -> counter wraps to 0. TRIGGER_REQ during DATA -> REQ_DROPPED pulse, no second trigger.
- With TLU_EMULATOR_RESET_EN, counter=7, RESET_REQ in IDLE -> TLU_RESET high TRIGGER_PULSE_LEN cycles, counter=0. BUS_RST_N low mid-DATA -> all outputs 0 immediately.
